// File: rtl/bcd2bin_sched_pkg.sv
// Shared definitions for the bcd2bin scheduler: FSM encoding, BCD limits and
// result width.
package bcd2bin_sched_pkg;

    localparam int BCD_MAX = 9;
    localparam int BIN_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd2bin_sched_rr_pick.sv
// Combinational round-robin picker: returns the first set request after
// 'last', wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  grant,
    output logic             valid
);

    logic [ID_W:0] idx;

    // Scan from the farthest candidate to the nearest so the nearest set bit
    // is the one left standing.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = {1'b0, last} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                grant = idx[ID_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd2bin_sched.sv
// Round-robin scheduler sharing one external bcd2bin converter among N_REQ
// requesters; rejects non-BCD digits and abandons conversions that time out.
module bcd2bin_sched
    import bcd2bin_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] bcd1_bus,
    input  logic [4*N_REQ-1:0] bcd0_bus,
    output logic [N_REQ-1:0]   ack,
    output logic               done_tick,
    output logic [ID_W-1:0]    done_id,
    output logic [BIN_W-1:0]   bin,
    output logic               err,
    output logic               busy,
    output logic               cvt_start,
    output logic [3:0]         cvt_bcd1,
    output logic [3:0]         cvt_bcd0,
    input  logic               cvt_ready,
    input  logic               cvt_done_tick,
    input  logic [BIN_W-1:0]   cvt_bin
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e             state_q;
    logic [ID_W-1:0]    last_q;
    logic [ID_W-1:0]    gnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   ack_q;
    logic               done_tick_q;
    logic [ID_W-1:0]    done_id_q;
    logic [BIN_W-1:0]   bin_q;
    logic               err_q;
    logic               busy_q;
    logic               cvt_start_q;
    logic [3:0]         cvt_bcd1_q;
    logic [3:0]         cvt_bcd0_q;

    logic [ID_W-1:0]    pick_id;
    logic               pick_vld;
    logic [3:0]         pick_bcd1;
    logic [3:0]         pick_bcd0;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .grant (pick_id),
        .valid (pick_vld)
    );

    assign pick_bcd1 = bcd1_bus[{pick_id, 2'b00} +: 4];
    assign pick_bcd0 = bcd0_bus[{pick_id, 2'b00} +: 4];

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values; the async reset branch covers every register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_W'(N_REQ-1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            done_tick_q <= 1'b0;
            done_id_q   <= '0;
            bin_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cvt_start_q <= 1'b0;
            cvt_bcd1_q  <= '0;
            cvt_bcd0_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld && cvt_ready) begin
                        gnt_q  <= pick_id;
                        busy_q <= 1'b1;
                        // Bad digits are answered directly; the converter never sees them.
                        if (!is_bcd(pick_bcd1) || !is_bcd(pick_bcd0)) begin
                            state_q     <= ST_RESP;
                            bin_q       <= '0;
                            err_q       <= 1'b1;
                            done_tick_q <= 1'b1;
                            done_id_q   <= pick_id;
                            ack_q       <= ONE_HOT0 << pick_id;
                        end else begin
                            state_q     <= ST_LAUNCH;
                            cvt_start_q <= 1'b1;
                            cvt_bcd1_q  <= pick_bcd1;
                            cvt_bcd0_q  <= pick_bcd0;
                        end
                    end
                end
                ST_LAUNCH: begin
                    cvt_start_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the timeout cycle still delivers its result.
                    if (cvt_done_tick) begin
                        state_q     <= ST_RESP;
                        bin_q       <= cvt_bin;
                        err_q       <= 1'b0;
                        done_tick_q <= 1'b1;
                        done_id_q   <= gnt_q;
                        ack_q       <= ONE_HOT0 << gnt_q;
                    end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                        state_q     <= ST_RESP;
                        bin_q       <= '0;
                        err_q       <= 1'b1;
                        done_tick_q <= 1'b1;
                        done_id_q   <= gnt_q;
                        ack_q       <= ONE_HOT0 << gnt_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    done_tick_q <= 1'b0;
                    ack_q       <= '0;
                    busy_q      <= 1'b0;
                    last_q      <= gnt_q;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign done_tick = done_tick_q;
    assign done_id   = done_id_q;
    assign bin       = bin_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign cvt_start = cvt_start_q;
    assign cvt_bcd1  = cvt_bcd1_q;
    assign cvt_bcd0  = cvt_bcd0_q;

endmodule

// File: doc/bcd2bin_sched.md
Name: bcd2bin_sched

Overview:
- Round-robin scheduler that shares one bcd2bin converter among N_REQ requesters.
- Each requester presents a 2-digit BCD value and holds a request. The scheduler grants one requester at a time, launches the converter, and waits for its done pulse.
- Returns the 7-bit binary result tagged with the requester id.
- Rejects non-BCD digits without using the converter, and recovers from a converter that never completes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must equal ceil(log2(N_REQ)).
- TIMEOUT, 64, maximum WAIT cycles before a conversion is abandoned (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  N_REQ  per-requester request level.
- bcd1_bus  in  4*N_REQ  tens digit; requester i occupies bits [4i+3:4i].
- bcd0_bus  in  4*N_REQ  units digit, same packing as bcd1_bus.
- ack  out  N_REQ  one-hot, one-cycle completion pulse to the served requester.
- done_tick  out  1  one-cycle pulse; result fields are valid this cycle.
- done_id  out  ID_W  id of the served requester.
- bin  out  7  binary result (0..99); 0 when err=1.
- err  out  1  set with done_tick if a digit was >9 or the conversion timed out.
- busy  out  1  high in every state except IDLE.
- cvt_start  out  1  converter start, one-cycle pulse.
- cvt_bcd1, cvt_bcd0  out  4 each  latched digits driven to the converter.
- cvt_ready  in  1  converter idle.
- cvt_done_tick  in  1  converter completion pulse.
- cvt_bin  in  7  converter result.

Behaviour:
- Reset (reset=0, async) clears all outputs to 0, sets state to IDLE, and sets the round-robin pointer last=N_REQ-1 so requester 0 has first priority.
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs are registered, Moore style.
- IDLE:
  - Leaves IDLE only if req!=0 and cvt_ready=1.
  - Grants g = first set req bit scanning last+1, last+2, ... modulo N_REQ.
  - Latches g, bcd1_bus[g], and bcd0_bus[g].
  - If either latched digit >9: go to RESP with err=1 and bin=0; the converter is untouched.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - cvt_start=1 for exactly this cycle; cvt_bcd1/cvt_bcd0 hold the latched digits until RESP ends.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - cvt_start=0; the counter increments each cycle.
  - On cvt_done_tick=1: capture cvt_bin, set err=0, go to RESP.
  - Else if the counter reaches TIMEOUT-1: bin=0, err=1, go to RESP.
  - If cvt_done_tick arrives in the same cycle as the timeout, the done wins.
  - A cvt_done_tick seen outside WAIT is ignored.
- RESP:
  - done_tick=1, ack[g]=1, done_id=g; bin and err are valid.
  - Set last=g, then return to IDLE.
  - bin, err and done_id hold their values until the next RESP.
- Latency:
  - Error path: grant cycle to done_tick is 1 cycle.
  - Normal path: done_tick comes 1 cycle after cvt_done_tick is sampled.
  - Minimum gap between successive grants is 1 IDLE cycle.
- Requester rules:
  - Hold req and the digits until ack.
  - If req drops after grant, the transaction still completes and ack still pulses.
  - A req held through its ack is treated as a new request and arbitrated fairly against the others.
- Fairness: with all req bits high, grants rotate 0,1,2,...,N_REQ-1,0,...
- Reset asserted mid-operation aborts immediately: no ack, no done_tick, cvt_start=0.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP;
  - BCD_MAX=9;
  - result width BIN_W=7.
- Sub-module rr_pick (combinational round-robin priority picker): inputs req and last; outputs the grant index and a valid flag. It is parameterised by N_REQ and reused by later arbiters.
- The bcd2bin converter stays outside the scheduler. The bench instantiates it and connects it through the cvt_* ports.

Test Plan:
- Single request: req[2] with 4,2 -> one cvt_start pulse; later done_tick with ack=0100, done_id=2, bin=42, err=0.
- Invalid digit: req[1] with 1,10 -> done_tick 1 cycle after grant, done_id=1, bin=0, err=1; cvt_start never asserts.
- Fairness: all four req high with digits (0,0),(9,9),(5,5),(1,0), held through 8 completions -> done_id order 0,1,2,3,0,1,2,3 and bin values 0,99,55,10 repeating.
- Timeout: tie cvt_done_tick=0 and issue a valid request -> done_tick exactly TIMEOUT+1 cycles after cvt_start (LAUNCH), with err=1 and bin=0; the next request is then served normally.
- Reset mid-WAIT: pull reset low for 1 cycle during WAIT -> all outputs 0 asynchronously; after release, req[0] with 3,7 is granted first and returns bin=37.
- Exhaustive sweep: one requester iterates all 100 valid digit pairs -> each bin equals 10*bcd1+bcd0 with err=0.
